// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// default reset PC and the word-alignment mask used for target checks.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  WORD_ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection: jump-register > jump > taken branch > sequential.
// Purely combinational; flags a target that is not word-aligned.
module next_pc_calc
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              is_jump,
    input  logic              is_branch,
    input  logic              branch_taken,
    input  logic              is_jump_reg,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [15:0]       imm16,
    input  logic [25:0]       addr26,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_tgt;

    always_comb begin
        br_off  = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
        // Jump keeps the 256 MB region of the delay-slot address.
        jmp_tgt = {pc_plus4[ADDR_W-1:28], addr26, 2'b00};

        next_pc = pc_plus4;
        if (is_jump_reg) begin
            next_pc = reg_target;
        end else if (is_jump) begin
            next_pc = jmp_tgt;
        end else if (is_branch && branch_taken) begin
            next_pc = pc_plus4 + br_off;
        end

        misaligned = |(next_pc[1:0] & WORD_ALIGN_MASK);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack and holds the word
// until the decoder accepts it. Min 2 cycles per instruction; stalls on ack/accept.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_accept,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              is_jump,
    input  logic              is_branch,
    input  logic              branch_taken,
    input  logic              is_jump_reg,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [15:0]       imm16,
    input  logic [25:0]       addr26,
    output logic              fault
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] pc_plus4_w;
    logic [ADDR_W-1:0] next_pc;
    logic              misaligned;

    assign pc_plus4_w = pc_q + ADDR_W'(4);

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc_plus4     (pc_plus4_w),
        .is_jump      (is_jump),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .is_jump_reg  (is_jump_reg),
        .reg_target   (reg_target),
        .imm16        (imm16),
        .addr26       (addr26),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        fault_d = fault_q;

        case (state_q)
            ST_FETCH: begin
                // Request is raised one edge after reset release, so an ack
                // seen while req_q is still low cannot belong to this fetch.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_accept) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    if (misaligned) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        req_d   = 1'b0;
                    end else begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign fault       = fault_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Owns the PC and drives a req/ack instruction-memory port.
- Holds the fetched word on instruction[31:0] for the decoder. On accept, consumes the decoder's is_jump/is_branch/imm16/addr26 plus the datapath's branch outcome, then computes and fetches the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (must be word-aligned).
- ADDR_W, 32, PC / memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ack  in  1  memory has returned data on imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instruction  out  32  held instruction word to the decoder.
- instr_valid  out  1  instruction is valid.
- instr_accept  in  1  downstream has executed instruction; advance.
- pc  out  ADDR_W  address of held/in-flight instruction.
- pc_plus4  out  ADDR_W  pc + 4.
- is_jump  in  1  from decoder: J-type jump.
- is_branch  in  1  from decoder: conditional branch.
- branch_taken  in  1  from datapath: branch condition true.
- is_jump_reg  in  1  from decoder: register jump (jr/jalr).
- reg_target  in  ADDR_W  register value for is_jump_reg.
- imm16  in  16  from decoder: branch offset.
- addr26  in  26  from decoder: jump target field.
- fault  out  1  misaligned target seen; sticky until reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FETCH, pc=RESET_PC.
  - instruction=0, instr_valid=0, fault=0, imem_req=0.
  - imem_addr=RESET_PC.
- First edge after rst_n high: imem_req=1.
- States: FETCH, HOLD, FAULT.
- FETCH:
  - imem_req=1; imem_addr=pc, stable while waiting.
  - On an edge with imem_ack=1: instruction<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD.
  - No ack: remain in FETCH; no timeout.
- HOLD:
  - instr_valid=1; instruction stable.
  - instr_accept=0: stay in HOLD.
  - instr_accept=1: sample the control inputs that cycle and compute next PC. Then pc<=next, instr_valid<=0, go to FETCH with imem_req<=1.
  - Throughput: one instruction per 2 cycles minimum (ack on first request cycle).
- Next-PC priority (highest first):
  - is_jump_reg: reg_target.
  - is_jump: {pc_plus4[31:28], addr26, 2'b00}.
  - is_branch & branch_taken: pc_plus4 + (sext(imm16) << 2).
  - otherwise: pc_plus4.
- Arithmetic is modulo 2^ADDR_W. pc=32'hFFFF_FFFC with no redirect wraps to 0. Negative offsets wrap likewise.
- is_branch with branch_taken=0 gives pc_plus4.
- If is_jump and is_branch are both high, jump wins.
- Misaligned target (next[1:0]!=0, only reachable via is_jump_reg):
  - Go to FAULT; pc<=offending target; fault<=1.
  - instr_valid=0, imem_req=0.
  - FAULT is left only by reset.
- Inputs are ignored outside the accept cycle:
  - instr_accept in FETCH/FAULT.
  - imem_ack outside FETCH.
- Reset mid-FETCH: request abandoned immediately. An ack arriving in the first cycle after reset release is ignored, since imem_req is still 0.

Decomposition:
- Shared package holds:
  - state encoding constants (FETCH, HOLD, FAULT);
  - the default RESET_PC;
  - the word-alignment mask.
- One combinational sub-module, next_pc_calc: inputs pc_plus4, control inputs, reg_target; outputs next_pc and misaligned.
- fetch_unit keeps the FSM and registers.

Test Plan:
1. Reset with RESET_PC=0, then rst_n high -> imem_req=1, imem_addr=0; ack with rdata=32'h2010FEFE -> next cycle instr_valid=1, instruction=32'h2010FEFE, pc=0, pc_plus4=4.
2. Sequential: accept at pc=0x10 with no redirect -> imem_addr=0x14. Ack delayed 3 cycles: imem_req and addr held steady throughout, instr_valid=0 until the ack edge.
3. Branch: pc=0x10, is_branch=1, branch_taken=1, imm16=16'hFFFD -> next pc=0x08. Same with branch_taken=0 -> 0x14.
4. Jump: pc=0x1000_0040, is_jump=1, addr26=26'h0000100 -> next pc=0x1000_0400. is_jump plus is_branch/taken with imm16=1 -> jump target still wins.
5. jr: reg_target=0x0000_0102 -> fault=1, state FAULT, imem_req stays 0 for 10 cycles, pc=0x102. Reset clears to pc=RESET_PC, fault=0.
6. Wrap and mid-op reset:
   - pc=0xFFFF_FFFC, accept with no redirect -> imem_addr=0.
   - Drop rst_n while in FETCH between edges -> imem_req=0 and pc=RESET_PC immediately (asynchronous).
   - Ack in the first post-release cycle -> ignored, instr_valid stays 0.
